// File: rtl/player_status_pkg.sv
// player_status_pkg: shared constants and round state encoding for the player status block
package player_status_pkg;
  localparam int ENEMY_NUM = 4;
  localparam int DELTA_W = 10;
  localparam int FULL_BLOOD = 100;
  localparam int FLASH_FRAMES = 8;
  localparam int SCORE_MAX = 9999;
  typedef enum logic [1:0] {
    READY = 2'd0,
    PLAY  = 2'd1,
    OVER  = 2'd2
  } game_state_t;
endpackage

// File: rtl/player_status_counter_delta.sv
// counter_delta: per-cycle increment of a wrapping upstream counter, gated by en
module counter_delta
  import player_status_pkg::*;
(
  input  logic               Clk,
  input  logic               Reset,
  input  logic [DELTA_W-1:0] cur,
  input  logic               en,
  output logic [DELTA_W-1:0] delta
);
  logic [DELTA_W-1:0] prev_q, prev_d;
  // modular difference against last cycle's value; prev always tracks cur
  always_comb begin
    prev_d = cur;
    delta = en ? cur - prev_q : '0;
  end
  // previous-value register
  always_ff @(posedge Clk) prev_q <= Reset ? '0 : prev_d;
endmodule

// File: rtl/player_status.sv
// player_status: aggregates enemy damage/score counters into blood, score, round FSM and hit flash
module player_status
  import player_status_pkg::*;
(
  input  logic                              Clk,
  input  logic                              Reset,
  input  logic                              game_frame_clk_rising_edge,
  input  logic                              Start,
  input  logic                              Godmode_On,
  input  logic [ENEMY_NUM-1:0][DELTA_W-1:0] Enemy_Total_Damage,
  input  logic [ENEMY_NUM-1:0][DELTA_W-1:0] Enemy_Score,
  output logic [6:0]                        Player_Blood,
  output logic [13:0]                       Total_Score,
  output logic [1:0]                        Game_State,
  output logic                              Round_Reset,
  output logic                              Hit_Flash
);
  game_state_t state_q, state_d;
  logic [6:0] blood_q, blood_d, blood_nx;
  logic [13:0] score_q, score_d;
  logic [14:0] score_sum;
  logic [3:0] flash_q, flash_d;
  logic [1:0] resync_q, resync_d;
  logic rr_q, rr_d;
  logic acc_en;
  logic [11:0] dsum, ssum;
  logic [ENEMY_NUM-1:0][DELTA_W-1:0] dmg_delta, scr_delta;

  assign acc_en = (state_q == PLAY) && (resync_q == 2'd0);

  for (genvar i = 0; i < ENEMY_NUM; i++) begin : g_delta
    counter_delta u_dmg (.Clk(Clk), .Reset(Reset), .cur(Enemy_Total_Damage[i]), .en(acc_en), .delta(dmg_delta[i]));
    counter_delta u_scr (.Clk(Clk), .Reset(Reset), .cur(Enemy_Score[i]), .en(acc_en), .delta(scr_delta[i]));
  end

  // adder trees; godmode suppresses damage only
  always_comb begin
    dsum = '0;
    ssum = '0;
    for (int k = 0; k < ENEMY_NUM; k++) begin
      dsum = dsum + 12'(dmg_delta[k]);
      ssum = ssum + 12'(scr_delta[k]);
    end
    if (Godmode_On) dsum = '0;
  end

  // round FSM, blood/score update, flash timer and resync countdown
  always_comb begin
    state_d = state_q;
    blood_d = blood_q;
    score_d = score_q;
    flash_d = '0;
    rr_d = 1'b0;
    resync_d = (resync_q != 2'd0) ? resync_q - 2'd1 : 2'd0;
    blood_nx = (dsum >= 12'(blood_q)) ? '0 : blood_q - dsum[6:0];
    score_sum = {1'b0, score_q} + 15'(ssum);
    case (state_q)
      READY: if (Start) begin
        state_d = PLAY;
        blood_d = 7'(FULL_BLOOD);
        score_d = '0;
        resync_d = 2'd2;
        rr_d = 1'b1;
      end
      PLAY: begin
        blood_d = blood_nx;
        score_d = (score_sum > 15'(SCORE_MAX)) ? 14'(SCORE_MAX) : score_sum[13:0];
        flash_d = (dsum != '0) ? 4'(FLASH_FRAMES) :
                  (game_frame_clk_rising_edge && flash_q != '0) ? flash_q - 4'd1 : flash_q;
        if (blood_nx == '0) state_d = OVER;
      end
      OVER: if (Start) state_d = READY;
      default: state_d = READY;
    endcase
  end

  // state registers
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= READY;
      blood_q <= 7'(FULL_BLOOD);
      score_q <= '0;
      flash_q <= '0;
      resync_q <= 2'd2;
      rr_q <= 1'b0;
    end else begin
      state_q <= state_d;
      blood_q <= blood_d;
      score_q <= score_d;
      flash_q <= flash_d;
      resync_q <= resync_d;
      rr_q <= rr_d;
    end
  end

  assign Player_Blood = blood_q;
  assign Total_Score = score_q;
  assign Game_State = state_q;
  assign Round_Reset = rr_q;
  assign Hit_Flash = (state_q == PLAY) && (flash_q != '0);
endmodule

// File: tb/tb_player_status.sv
// tb_player_status: directed and randomized checks of player_status against a behavioural model
module tb_player_status;
  logic Clk = 1'b0;
  logic Reset = 1'b1, frame = 1'b0, Start = 1'b0, God = 1'b0;
  logic [3:0][9:0] dmg_v = '0, scr_v = '0;
  logic [6:0] Player_Blood;
  logic [13:0] Total_Score;
  logic [1:0] Game_State;
  logic Round_Reset, Hit_Flash;
  int n_chk = 0, n_pass = 0;
  int m_state = 0, m_blood = 100, m_score = 0, m_flash = 0, m_resync = 2, m_rr = 0;
  int m_prev_d[4] = '{0, 0, 0, 0};
  int m_prev_s[4] = '{0, 0, 0, 0};

  player_status dut (
    .Clk(Clk), .Reset(Reset), .game_frame_clk_rising_edge(frame), .Start(Start),
    .Godmode_On(God), .Enemy_Total_Damage(dmg_v), .Enemy_Score(scr_v),
    .Player_Blood(Player_Blood), .Total_Score(Total_Score), .Game_State(Game_State),
    .Round_Reset(Round_Reset), .Hit_Flash(Hit_Flash)
  );

  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  task automatic step();
    int dsum, ssum, ns, nb, nsc, nf, nrs, nrr, old_rr;
    dsum = 0;
    ssum = 0;
    for (int i = 0; i < 4; i++) begin
      dsum += (int'(dmg_v[i]) - m_prev_d[i] + 1024) % 1024;
      ssum += (int'(scr_v[i]) - m_prev_s[i] + 1024) % 1024;
    end
    if (!(m_state == 1 && m_resync == 0)) begin
      dsum = 0;
      ssum = 0;
    end
    if (God) dsum = 0;
    ns = m_state; nb = m_blood; nsc = m_score; nf = 0; nrr = 0;
    nrs = (m_resync > 0) ? m_resync - 1 : 0;
    if (Reset) begin
      ns = 0; nb = 100; nsc = 0; nrs = 2;
    end else if (m_state == 0) begin
      if (Start) begin ns = 1; nb = 100; nsc = 0; nrs = 2; nrr = 1; end
    end else if (m_state == 1) begin
      nb = (dsum >= m_blood) ? 0 : m_blood - dsum;
      nsc = (m_score + ssum > 9999) ? 9999 : m_score + ssum;
      nf = (dsum != 0) ? 8 : ((frame && m_flash > 0) ? m_flash - 1 : m_flash);
      if (nb == 0) ns = 2;
    end else if (Start) ns = 0;
    for (int i = 0; i < 4; i++) begin
      m_prev_d[i] = Reset ? 0 : int'(dmg_v[i]);
      m_prev_s[i] = Reset ? 0 : int'(scr_v[i]);
    end
    old_rr = m_rr;
    @(posedge Clk);
    #1;
    m_state = ns; m_blood = nb; m_score = nsc; m_flash = nf; m_resync = nrs; m_rr = nrr;
    if (Reset || old_rr != 0) begin
      dmg_v = '0;
      scr_v = '0;
    end
    chk("blood", int'(Player_Blood), m_blood);
    chk("score", int'(Total_Score), m_score);
    chk("state", int'(Game_State), m_state);
    chk("round_reset", int'(Round_Reset), m_rr);
    chk("hit_flash", int'(Hit_Flash), (m_state == 1 && m_flash != 0) ? 1 : 0);
  endtask

  task automatic pulse_start();
    Start = 1'b1;
    step();
    Start = 1'b0;
  endtask

  task automatic frames(input int n);
    frame = 1'b1;
    repeat (n) step();
    frame = 1'b0;
  endtask

  initial begin
    step();
    Reset = 1'b0;
    step();
    chk("reset_blood", int'(Player_Blood), 100);
    chk("reset_state", int'(Game_State), 0);
    pulse_start();
    chk("start_rr", int'(Round_Reset), 1);
    chk("start_state", int'(Game_State), 1);
    step();
    chk("rr_one_cycle", int'(Round_Reset), 0);
    step();
    God = 1'b1; dmg_v[2] = 10'd20; step(); God = 1'b0;
    dmg_v[0] = 10'd10; dmg_v[2] = 10'd30; step();
    chk("two_hits_blood", int'(Player_Blood), 80);
    chk("two_hits_flash", int'(Hit_Flash), 1);
    frames(7);
    chk("flash_7_frames", int'(Hit_Flash), 1);
    frames(1);
    chk("flash_8_frames", int'(Hit_Flash), 0);
    God = 1'b1; dmg_v[1] = 10'd1020; step(); God = 1'b0;
    dmg_v[1] = 10'd6; step();
    chk("wrap_blood", int'(Player_Blood), 70);
    frames(8);
    God = 1'b1; dmg_v[0] = dmg_v[0] + 10'd30; scr_v[0] = scr_v[0] + 10'd3; step(); God = 1'b0;
    chk("god_blood", int'(Player_Blood), 70);
    chk("god_flash", int'(Hit_Flash), 0);
    chk("god_score", int'(Total_Score), 3);
    dmg_v[3] = dmg_v[3] + 10'd55; step();
    chk("blood_15", int'(Player_Blood), 15);
    dmg_v[3] = dmg_v[3] + 10'd20; step();
    chk("kill_blood", int'(Player_Blood), 0);
    chk("kill_state", int'(Game_State), 2);
    dmg_v[0] = dmg_v[0] + 10'd5; scr_v[1] = scr_v[1] + 10'd2; step();
    chk("over_frozen_score", int'(Total_Score), 3);
    pulse_start();
    chk("over_to_ready", int'(Game_State), 0);
    for (int i = 0; i < 4; i++) begin dmg_v[i] = 10'd50; scr_v[i] = 10'd50; end
    step();
    pulse_start();
    repeat (4) step();
    chk("resync_blood", int'(Player_Blood), 100);
    chk("resync_score", int'(Total_Score), 0);
    repeat (624) begin
      for (int i = 0; i < 4; i++) scr_v[i] = scr_v[i] + 10'd4;
      step();
    end
    scr_v[0] = scr_v[0] + 10'd6; step();
    chk("score_9990", int'(Total_Score), 9990);
    for (int i = 0; i < 4; i++) scr_v[i] = scr_v[i] + 10'd5;
    step();
    chk("score_sat", int'(Total_Score), 9999);
    repeat (3000) begin
      frame = ($urandom % 4) == 0;
      Start = ($urandom % 40) == 0;
      God = ($urandom % 8) == 0;
      Reset = ($urandom % 400) == 0;
      for (int i = 0; i < 4; i++) begin
        if ($urandom % 12 == 0) dmg_v[i] = dmg_v[i] + 10'($urandom % 6);
        if ($urandom % 6 == 0) scr_v[i] = scr_v[i] + 10'($urandom % 4);
      end
      step();
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
